// File: rtl/klavye_pkg.sv
// Shared scan-code constants, FSM state encoding and modifier classification
// for the PS/2 keyboard event sequencer.
package klavye_pkg;

    localparam logic [7:0] KOPMA_ON = 8'hF0;
    localparam logic [7:0] GENIS_ON = 8'hE0;
    localparam logic [7:0] KOD_BOS  = 8'h00;
    localparam logic [7:0] KOD_TASMA = 8'hFF;

    localparam logic [7:0] KOD_LSHIFT = 8'h12;
    localparam logic [7:0] KOD_RSHIFT = 8'h59;
    localparam logic [7:0] KOD_CTRL   = 8'h14;
    localparam logic [7:0] KOD_ALT    = 8'h11;
    localparam logic [7:0] KOD_CAPS   = 8'h58;
    localparam logic [7:0] KOD_NUM    = 8'h77;

    typedef enum logic [1:0] {
        BEKLE       = 2'd0,
        KOPMA       = 2'd1,
        GENIS       = 2'd2,
        GENIS_KOPMA = 2'd3
    } durum_t;

    // The modifier set is matched on the bare code; the E0 prefix is irrelevant.
    function automatic logic is_modifier(input logic [7:0] kod);
        return (kod == KOD_LSHIFT) || (kod == KOD_RSHIFT) || (kod == KOD_CTRL) ||
               (kod == KOD_ALT)    || (kod == KOD_CAPS)   || (kod == KOD_NUM);
    endfunction

endpackage

// File: rtl/tekrar_zamanlayici.sv
// Typematic repeat counter: loads the initial delay or the repeat period and
// flags the cycle on which the held key is due for another event.
module tekrar_zamanlayici #(
    parameter int TEKRAR_GECIKME = 50,
    parameter int TEKRAR_PERIYOT = 10,
    parameter int SAYAC_W        = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load_gecikme,
    input  logic i_load_periyot,
    input  logic i_durdur,
    output logic o_tetik
);
    import klavye_pkg::*;

    localparam logic [SAYAC_W-1:0] GECIKME_YUK = SAYAC_W'(TEKRAR_GECIKME);
    localparam logic [SAYAC_W-1:0] PERIYOT_YUK = SAYAC_W'(TEKRAR_PERIYOT);

    logic [SAYAC_W-1:0] r_sayac;

    // Zero means idle; the counter never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sayac <= '0;
        end else if (i_durdur) begin
            r_sayac <= '0;
        end else if (i_load_gecikme) begin
            r_sayac <= GECIKME_YUK;
        end else if (i_load_periyot) begin
            r_sayac <= PERIYOT_YUK;
        end else if (r_sayac != '0) begin
            r_sayac <= r_sayac - 1'b1;
        end
    end

    assign o_tetik = (r_sayac == SAYAC_W'(1));

endmodule

// File: rtl/klavye_olay_siralayici.sv
// Turns raw PS/2 set-2 bytes into single-cycle character events with typematic
// repeat, plus a held-modifier level for klavye_kontrolcu.
module klavye_olay_siralayici #(
    parameter int TEKRAR_GECIKME = 50,
    parameter int TEKRAR_PERIYOT = 10,
    parameter int SAYAC_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bayt_gecerli,
    input  logic [7:0] bayt,
    output logic       buton_aktif,
    output logic [7:0] buton_giris,
    output logic       buton_genis,
    output logic       kontrol_aktif,
    output logic [7:0] kontrol_giris,
    output logic       hata
);
    import klavye_pkg::*;

    durum_t     r_durum;
    durum_t     w_durum_next;
    logic       r_buton_aktif;
    logic [7:0] r_buton_giris;
    logic       r_buton_genis;
    logic       r_kontrol_aktif;
    logic [7:0] r_kontrol_giris;
    logic       r_hata;
    logic       r_tutulan_var;
    logic [7:0] r_tutulan_kod;
    logic       r_tutulan_genis;

    logic w_make;
    logic w_break;
    logic w_genis;
    logic w_hata;
    logic w_gecersiz;
    logic w_mod;
    logic w_ayni;
    logic w_yeni_make;
    logic w_tutulan_kopma;
    logic w_tekrar;
    logic w_tetik;

    assign w_gecersiz = (bayt == KOD_BOS) || (bayt == KOD_TASMA);

    always_comb begin
        w_durum_next = r_durum;
        w_make       = 1'b0;
        w_break      = 1'b0;
        w_genis      = 1'b0;
        w_hata       = 1'b0;
        if (bayt_gecerli) begin
            case (r_durum)
                BEKLE: begin
                    if (bayt == KOPMA_ON)      w_durum_next = KOPMA;
                    else if (bayt == GENIS_ON) w_durum_next = GENIS;
                    else if (w_gecersiz)       w_hata = 1'b1;
                    else                       w_make = 1'b1;
                end
                KOPMA: begin
                    w_durum_next = BEKLE;
                    if (bayt == KOPMA_ON || bayt == GENIS_ON || w_gecersiz) w_hata = 1'b1;
                    else                                                   w_break = 1'b1;
                end
                GENIS: begin
                    w_genis = 1'b1;
                    if (bayt == KOPMA_ON) begin
                        w_durum_next = GENIS_KOPMA;
                    end else begin
                        w_durum_next = BEKLE;
                        if (bayt == GENIS_ON || w_gecersiz) w_hata = 1'b1;
                        else                                w_make = 1'b1;
                    end
                end
                default: begin
                    w_genis      = 1'b1;
                    w_durum_next = BEKLE;
                    if (bayt == KOPMA_ON || bayt == GENIS_ON || w_gecersiz) w_hata = 1'b1;
                    else                                                   w_break = 1'b1;
                end
            endcase
        end
    end

    assign w_mod  = is_modifier(bayt);
    assign w_ayni = r_tutulan_var && (r_tutulan_kod == bayt) && (r_tutulan_genis == w_genis);

    // A fresh make or the release of the held key both pre-empt a due repeat.
    assign w_yeni_make     = w_make  && !w_mod && !w_ayni;
    assign w_tutulan_kopma = w_break && !w_mod &&  w_ayni;
    assign w_tekrar        = w_tetik && r_tutulan_var && !w_yeni_make && !w_tutulan_kopma;

    tekrar_zamanlayici #(
        .TEKRAR_GECIKME (TEKRAR_GECIKME),
        .TEKRAR_PERIYOT (TEKRAR_PERIYOT),
        .SAYAC_W        (SAYAC_W)
    ) u_tekrar (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_load_gecikme (w_yeni_make),
        .i_load_periyot (w_tekrar),
        .i_durdur       (w_tutulan_kopma),
        .o_tetik        (w_tetik)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_durum         <= BEKLE;
            r_buton_aktif   <= 1'b0;
            r_buton_giris   <= 8'h00;
            r_buton_genis   <= 1'b0;
            r_kontrol_aktif <= 1'b0;
            r_kontrol_giris <= 8'h00;
            r_hata          <= 1'b0;
            r_tutulan_var   <= 1'b0;
            r_tutulan_kod   <= 8'h00;
            r_tutulan_genis <= 1'b0;
        end else begin
            r_durum       <= w_durum_next;
            r_hata        <= w_hata;
            r_buton_aktif <= w_yeni_make || w_tekrar;

            if (w_yeni_make) begin
                r_buton_giris   <= bayt;
                r_buton_genis   <= w_genis;
                r_tutulan_var   <= 1'b1;
                r_tutulan_kod   <= bayt;
                r_tutulan_genis <= w_genis;
            end else if (w_tutulan_kopma) begin
                r_tutulan_var <= 1'b0;
            end else if (w_tekrar) begin
                r_buton_giris <= r_tutulan_kod;
                r_buton_genis <= r_tutulan_genis;
            end

            // Single modifier slot: last make wins, only a matching break clears it.
            if (w_make && w_mod) begin
                r_kontrol_aktif <= 1'b1;
                r_kontrol_giris <= bayt;
            end else if (w_break && w_mod && r_kontrol_aktif && (bayt == r_kontrol_giris)) begin
                r_kontrol_aktif <= 1'b0;
                r_kontrol_giris <= 8'h00;
            end
        end
    end

    assign buton_aktif   = r_buton_aktif;
    assign buton_giris   = r_buton_giris;
    assign buton_genis   = r_buton_genis;
    assign kontrol_aktif = r_kontrol_aktif;
    assign kontrol_giris = r_kontrol_giris;
    assign hata          = r_hata;

endmodule

// File: tb/tb_klavye_olay_siralayici.sv
// Directed bench for klavye_olay_siralayici: scan-code sequences with
// hand-computed event, modifier, repeat-timing and error expectations.
module tb_klavye_olay_siralayici;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bayt_gecerli = 1'b0;
    logic [7:0] bayt = 8'h00;
    logic       buton_aktif;
    logic [7:0] buton_giris;
    logic       buton_genis;
    logic       kontrol_aktif;
    logic [7:0] kontrol_giris;
    logic       hata;

    klavye_olay_siralayici #(
        .TEKRAR_GECIKME (50),
        .TEKRAR_PERIYOT (10),
        .SAYAC_W        (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bayt_gecerli  (bayt_gecerli),
        .bayt          (bayt),
        .buton_aktif   (buton_aktif),
        .buton_giris   (buton_giris),
        .buton_genis   (buton_genis),
        .kontrol_aktif (kontrol_aktif),
        .kontrol_giris (kontrol_giris),
        .hata          (hata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int darbe_sayisi = 0;
    int hata_sayisi = 0;
    int darbe_zaman[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled mid-cycle, stamped with the cycle count after the edge.
    always @(negedge clk) begin
        if (buton_aktif) begin
            darbe_sayisi <= darbe_sayisi + 1;
            darbe_zaman.push_back(cyc);
        end
        if (hata) hata_sayisi <= hata_sayisi + 1;
    end

    task automatic kontrol_et(input string tag, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        n_checks++;
        if (gozlenen !== beklenen) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, gozlenen, beklenen);
        end
    endtask

    task automatic gonder(input logic [7:0] b);
        bayt         = b;
        bayt_gecerli = 1'b1;
        @(posedge clk);
        #1;
        bayt_gecerli = 1'b0;
        bayt         = 8'h00;
    endtask

    task automatic bekle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic zaman_kontrol(input string tag, input int idx, input int t0, input int beklenen);
        if (idx < darbe_zaman.size()) kontrol_et(tag, 32'(darbe_zaman[idx] - t0), 32'(beklenen));
        else                          kontrol_et(tag, 32'hFFFF_FFFF, 32'(beklenen));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int base;
        int snap;

        // Reset state
        bekle(3);
        kontrol_et("rst_buton_aktif", 32'(buton_aktif), 0);
        kontrol_et("rst_buton_giris", 32'(buton_giris), 0);
        kontrol_et("rst_kontrol_aktif", 32'(kontrol_aktif), 0);
        kontrol_et("rst_kontrol_giris", 32'(kontrol_giris), 0);
        kontrol_et("rst_hata", 32'(hata), 0);
        rst_n = 1'b1;
        bekle(2);

        // Simple make then break before the repeat delay
        snap = darbe_sayisi;
        base = hata_sayisi;
        gonder(8'h1C);
        $display("tx make 1C: aktif=%0b giris=%02h genis=%0b", buton_aktif, buton_giris, buton_genis);
        kontrol_et("make1c_aktif", 32'(buton_aktif), 1);
        kontrol_et("make1c_giris", 32'(buton_giris), 32'h1C);
        kontrol_et("make1c_genis", 32'(buton_genis), 0);
        bekle(1);
        kontrol_et("make1c_tek_darbe", 32'(buton_aktif), 0);
        bekle(5);
        gonder(8'hF0);
        gonder(8'h1C);
        bekle(60);
        $display("tx break 1C: pulses=%0d errors=%0d", darbe_sayisi - snap, hata_sayisi - base);
        kontrol_et("break1c_darbe", 32'(darbe_sayisi - snap), 1);
        kontrol_et("break1c_hata", 32'(hata_sayisi - base), 0);

        // Modifier level with a character key in between
        gonder(8'h12);
        $display("tx make 12: kontrol_aktif=%0b kontrol_giris=%02h", kontrol_aktif, kontrol_giris);
        kontrol_et("mod12_aktif", 32'(kontrol_aktif), 1);
        kontrol_et("mod12_giris", 32'(kontrol_giris), 32'h12);
        kontrol_et("mod12_buton", 32'(buton_aktif), 0);
        gonder(8'h44);
        $display("tx make 44: aktif=%0b giris=%02h kontrol=%02h", buton_aktif, buton_giris, kontrol_giris);
        kontrol_et("mod_44_aktif", 32'(buton_aktif), 1);
        kontrol_et("mod_44_giris", 32'(buton_giris), 32'h44);
        kontrol_et("mod_44_kontrol", 32'(kontrol_giris), 32'h12);
        gonder(8'hF0);
        gonder(8'h44);
        gonder(8'hF0);
        gonder(8'h12);
        $display("tx break 12: kontrol_aktif=%0b kontrol_giris=%02h", kontrol_aktif, kontrol_giris);
        kontrol_et("mod12_kopma_aktif", 32'(kontrol_aktif), 0);
        kontrol_et("mod12_kopma_giris", 32'(kontrol_giris), 0);
        bekle(3);

        // Typematic repeat with echo bytes, one echo landing on the expiry cycle
        base = darbe_zaman.size();
        gonder(8'h32);
        t0 = cyc;
        bekle(19);
        gonder(8'h32);
        bekle(29);
        gonder(8'h32);
        bekle(24);
        gonder(8'hF0);
        gonder(8'h32);
        bekle(20);
        $display("tx hold 32: pulses=%0d", darbe_zaman.size() - base);
        kontrol_et("tekrar_adet", 32'(darbe_zaman.size() - base), 4);
        zaman_kontrol("tekrar_t1", base + 0, t0, 0);
        zaman_kontrol("tekrar_t51", base + 1, t0, 50);
        zaman_kontrol("tekrar_t61", base + 2, t0, 60);
        zaman_kontrol("tekrar_t71", base + 3, t0, 70);

        // Extended key: plain break ignored, extended break stops repeat
        gonder(8'hE0);
        base = darbe_zaman.size();
        gonder(8'h6C);
        t0 = cyc;
        $display("tx make E0 6C: aktif=%0b giris=%02h genis=%0b", buton_aktif, buton_giris, buton_genis);
        kontrol_et("genis_aktif", 32'(buton_aktif), 1);
        kontrol_et("genis_giris", 32'(buton_giris), 32'h6C);
        kontrol_et("genis_bayrak", 32'(buton_genis), 1);
        bekle(3);
        gonder(8'hF0);
        gonder(8'h6C);
        bekle(50);
        kontrol_et("genis_duz_kopma_yoksay", 32'(darbe_zaman.size() - base), 2);
        zaman_kontrol("genis_tekrar_t51", base + 1, t0, 50);
        kontrol_et("genis_tekrar_bayrak", 32'(buton_genis), 1);
        gonder(8'hE0);
        gonder(8'hF0);
        gonder(8'h6C);
        bekle(30);
        $display("tx break E0 F0 6C: pulses=%0d", darbe_zaman.size() - base);
        kontrol_et("genis_kopma_dur", 32'(darbe_zaman.size() - base), 2);

        // Protocol errors
        gonder(8'hF0);
        gonder(8'hF0);
        $display("tx F0 F0: hata=%0b", hata);
        kontrol_et("f0f0_hata", 32'(hata), 1);
        bekle(1);
        kontrol_et("f0f0_hata_tek", 32'(hata), 0);
        gonder(8'h4C);
        kontrol_et("f0f0_sonra_aktif", 32'(buton_aktif), 1);
        kontrol_et("f0f0_sonra_giris", 32'(buton_giris), 32'h4C);
        kontrol_et("f0f0_sonra_genis", 32'(buton_genis), 0);
        gonder(8'hF0);
        gonder(8'h4C);
        bekle(2);
        gonder(8'hFF);
        $display("tx FF: hata=%0b aktif=%0b giris=%02h", hata, buton_aktif, buton_giris);
        kontrol_et("ff_hata", 32'(hata), 1);
        kontrol_et("ff_aktif", 32'(buton_aktif), 0);
        kontrol_et("ff_giris", 32'(buton_giris), 32'h4C);
        kontrol_et("ff_kontrol", 32'(kontrol_aktif), 0);
        bekle(2);

        // Reset mid-repeat with a dangling break prefix
        gonder(8'h1C);
        bekle(55);
        gonder(8'hF0);
        rst_n = 1'b0;
        #1;
        $display("tx reset: aktif=%0b giris=%02h kontrol=%0b hata=%0b", buton_aktif, buton_giris, kontrol_aktif, hata);
        kontrol_et("rst2_aktif", 32'(buton_aktif), 0);
        kontrol_et("rst2_giris", 32'(buton_giris), 0);
        kontrol_et("rst2_kontrol", 32'(kontrol_aktif), 0);
        kontrol_et("rst2_hata", 32'(hata), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        snap = darbe_sayisi;
        bekle(80);
        kontrol_et("rst2_tekrar_yok", 32'(darbe_sayisi - snap), 0);
        gonder(8'h1C);
        $display("tx make 1C after reset: aktif=%0b giris=%02h hata=%0b", buton_aktif, buton_giris, hata);
        kontrol_et("rst2_make_aktif", 32'(buton_aktif), 1);
        kontrol_et("rst2_make_giris", 32'(buton_giris), 32'h1C);
        kontrol_et("rst2_make_hata", 32'(hata), 0);
        gonder(8'hF0);
        gonder(8'h1C);
        bekle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
